// File: rtl/chess_pkg.sv
// chess_pkg: shared piece, move-encoding and move-collector constants
package chess_pkg;
   typedef enum logic [2:0] {EMPTY, PAWN, KNIGHT, BISHOP, ROOK, QUEEN, KING} piece_t;
   localparam logic WHITE = 1'b0;
   localparam logic BLACK = 1'b1;
   localparam int MOVE_W = 19;
   localparam int SLOTS = 8;
   localparam int FIFO_W = 160;
   localparam int WORD_W = SLOTS * MOVE_W;
   localparam int FLG_CAPTURE = 12;
   localparam int FLG_CASTLE = 13;
   localparam int FLG_EP = 14;
   localparam int FLG_PAWN2 = 15;
   localparam int FLG_PAWN = 16;
   localparam int FLG_PROMOTE = 17;
   localparam int FLG_INVALID = 18;
   localparam logic [MOVE_W-1:0] IMOV = 19'h40000;
   typedef enum logic [2:0] {ST_IDLE, ST_SCAN, ST_READ, ST_WAIT, ST_UNPK, ST_FINI} state_t;
   function automatic logic is_invalid(input logic [MOVE_W-1:0] m);
      return m[FLG_INVALID];
   endfunction
endpackage

// File: rtl/move_collector_rr_pick.sv
// rr_pick: round-robin picker, first set request at or after the base pointer, wrapping
module rr_pick #(
   parameter int N = 64,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_base,
   output logic         o_hit,
   output logic [W-1:0] o_idx
);
   logic [N-1:0] w_rot;
   logic [W-1:0] w_pos;
   // Rotate so the base pointer lands on bit 0
   always_comb begin
      w_rot = '0;
      for (int i = 0; i < N; i++) w_rot[i] = i_req[(i + int'(i_base)) % N];
   end
   // Lowest set bit of the rotated vector is the nearest request after the base
   always_comb begin
      w_pos = '0;
      for (int i = N - 1; i >= 0; i--) if (w_rot[i]) w_pos = W'(i);
   end
   assign o_hit = |w_rot;
   assign o_idx = W'((int'(w_pos) + int'(i_base)) % N);
endmodule

// File: rtl/move_collector.sv
// move_collector: drains the per-square move FIFOs and streams valid moves over valid/ready
import chess_pkg::*;
module move_collector #(
   parameter int NUM_SQ = 64,
   parameter int CNT_W = 10
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic [NUM_SQ*FIFO_W-1:0] i_fifo_q,
   input  logic [NUM_SQ-1:0]        i_fifo_empty,
   input  logic [NUM_SQ-1:0]        i_sq_done,
   output logic [NUM_SQ-1:0]        o_rden,
   output logic [MOVE_W-1:0]        o_move_out,
   output logic                     o_move_valid,
   input  logic                     i_move_ready,
   output logic [CNT_W-1:0]         o_move_count,
   output logic                     o_all_done
);
   localparam int SW = $clog2(NUM_SQ);
   localparam int KW = $clog2(SLOTS);
   state_t r_state;
   logic [SW-1:0] r_ptr, r_sel, w_idx;
   logic [WORD_W-1:0] r_word, w_q;
   logic [SLOTS-1:0] r_pend, w_pend_nx, w_new_pend;
   logic [CNT_W-1:0] r_cnt;
   logic [KW-1:0] w_slot;
   logic w_hit, w_xfer;
   rr_pick #(.N(NUM_SQ)) u_pick (
      .i_req (~i_fifo_empty),
      .i_base(r_ptr),
      .o_hit (w_hit),
      .o_idx (w_idx)
   );
   assign w_q = i_fifo_q[int'(r_sel)*FIFO_W +: WORD_W];
   // A slot is live when its invalid flag is clear
   always_comb begin
      w_new_pend = '0;
      for (int k = 0; k < SLOTS; k++) w_new_pend[k] = ~is_invalid(w_q[MOVE_W*k +: MOVE_W]);
   end
   // Lowest pending slot goes next, so slots leave in ascending order
   always_comb begin
      w_slot = '0;
      for (int k = SLOTS - 1; k >= 0; k--) if (r_pend[k]) w_slot = KW'(k);
   end
   assign o_move_out   = r_word[int'(w_slot)*MOVE_W +: MOVE_W];
   assign o_move_valid = (r_state == ST_UNPK) && |r_pend;
   assign w_xfer       = o_move_valid && i_move_ready;
   assign w_pend_nx    = w_xfer ? r_pend & (r_pend - 1'b1) : r_pend;
   assign o_rden       = (r_state == ST_READ) ? NUM_SQ'(1) << r_sel : '0;
   assign o_all_done   = r_state == ST_FINI;
   assign o_move_count = r_cnt;
   // Collection FSM: scan for a non-empty FIFO, read it, latch the word, emit its live slots
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_word  <= '0;
         r_pend  <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_FINI: if (i_start) begin
               r_cnt   <= '0;
               r_ptr   <= '0;
               r_state <= ST_SCAN;
            end
            ST_SCAN: if (w_hit) begin
               r_sel   <= w_idx;
               r_ptr   <= (w_idx == SW'(NUM_SQ - 1)) ? '0 : w_idx + 1'b1;
               r_state <= ST_READ;
            end else if (&i_sq_done) r_state <= ST_FINI;
            ST_READ: r_state <= ST_WAIT;
            ST_WAIT: begin
               r_word  <= w_q;
               r_pend  <= w_new_pend;
               r_state <= ST_UNPK;
            end
            ST_UNPK: begin
               r_pend <= w_pend_nx;
               if (w_xfer && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
               if (w_pend_nx == '0) r_state <= ST_SCAN;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/move_collector.md
# move_collector

Drain side of the per-square move FIFOs. After a board evaluation starts, the block scans the 64 square-unit FIFOs, pops each 160-bit word, and unpacks the eight 19-bit move slots. It discards invalid slots and streams the valid moves one per cycle to the search/evaluation logic over a valid/ready handshake. It raises `all_done` once every square has reported done and every FIFO is empty.

## Interface
- `NUM_SQ`, 64: number of square units / FIFOs.
- `CNT_W`, 10: width of the move counter; saturates at all-ones.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high; returns the block to IDLE.
- `start` in 1: one-cycle pulse that begins collection; ignored unless in IDLE or FINI.
- `fifo_q` in NUM_SQ*160: flat FIFO data; square i occupies bits [160*i+159 : 160*i].
- `fifo_empty` in NUM_SQ: per-square FIFO empty flag.
- `sq_done` in NUM_SQ: per-square done level.
- `rden` out NUM_SQ: per-square read request; one-hot or zero.
- `move_out` out 19: {7b flag, 6b from, 6b to}; flag = {invalid, promote, pawn move, pawn 2 sq, en passant, castle, capture}.
- `move_valid` out 1: `move_out` is valid.
- `move_ready` in 1: consumer accepts; a transfer occurs when valid && ready.
- `move_count` out CNT_W: number of moves transferred since `start`.
- `all_done` out 1: level; collection complete.

## Operation
- States: IDLE, SCAN, READ, WAIT, UNPK, FINI.
- **IDLE**: on `start`, clear `move_count`, set scan pointer `ptr` = 0, go to SCAN.
- **SCAN**: rotate `~fifo_empty` by `ptr` and pick the first non-empty index at or after `ptr`, wrapping.
  - On a hit: latch `sel`, set `ptr` = sel+1 mod NUM_SQ, go to READ.
  - No hit and `&sq_done`: go to FINI.
  - Otherwise stay in SCAN.
- **READ**: `rden[sel]` = 1 for exactly this cycle, then go to WAIT.
- **WAIT**: register `fifo_q[sel]` into `word`. Build `pend[k]` = ~word[19k+18] for k = 0..7, then go to UNPK.
- **UNPK**: `move_out` = slot at the lowest set bit of `pend`; `move_valid` = |pend.
  - On each transfer: clear that `pend` bit and increment `move_count` (saturating).
  - When `pend` is zero, or becomes zero on the current transfer, go to SCAN. Slots are emitted in order 0 to 7.
  - A word with no valid slots spends one UNPK cycle with `move_valid` = 0, then goes to SCAN.
- **FINI**: `all_done` = 1. `start` begins a new collection and clears `all_done` on the next cycle.
- Bits [159:152] of each word are ignored.
- If `move_ready` is low, hold `move_out` and `move_valid` stable.

## Timing
- Reset values: state IDLE, `rden` 0, `move_valid` 0, `move_out` 0, `move_count` 0, `all_done` 0, `ptr` 0.
- `rden` and `move_valid` decode from registered state, `sel` and `pend`; they never depend combinationally on `move_ready`. `move_out` is a mux of registered `word`.
- FIFO read latency is 1: `q` is valid in the cycle after the `rden` cycle.
- Cycle sequence from `start` at cycle 0:
  - cycle 1: SCAN
  - cycle 2: READ
  - cycle 3: WAIT
  - cycle 4: first `move_valid`
- With `move_ready` held high, one move transfers per cycle. Per-word overhead is 3 cycles (SCAN, READ, WAIT).
- Reset mid-operation: the next cycle is IDLE with `rden` 0. A word latched in `word` is dropped.
- If `start` and `reset` are asserted together, `reset` wins.
- `sq_done` rising while in SCAN, with some FIFO still non-empty: keep draining. FINI is entered only when all FIFOs are empty and all squares are done in the same cycle.
- `move_count` holds at 2^CNT_W-1 once it saturates.

## Structure
- Shared package `chess_pkg`: piece codes (EMPTY..KING), colour bits, move-flag bit positions, `MOVE_W` = 19, `SLOTS` = 8, `FIFO_W` = 160, `IMOV` constant.
- One sub-module: `rr_pick`. It takes a NUM_SQ request vector and a base pointer and returns hit plus index, using the rotate, priority-encode, un-rotate method.
- The 8-slot lowest-set-bit picker is inline.

## Test plan
- Single word: FIFO 12 holds a word with slots 0 and 3 valid (slot 0 = {7'b0000000, 6'o14, 6'o24}); all squares done. Required: `rden[12]` pulses once, two moves out in slot order, `move_count` = 2, `all_done` is set.
- Round-robin: FIFOs 5 and 40 non-empty, `ptr` = 0. Required: 5 is read before 40. After refilling 5, 40 is served first on the next scan.
- Backpressure: `move_ready` low for 4 cycles during UNPK. Required: `move_out` stable and no duplicate or lost moves.
- All-invalid word: all eight slot bit-18s set. Required: zero transfers, return to SCAN, `move_count` unchanged.
- Done gating: all FIFOs empty but `sq_done[63]` = 0 for 10 cycles. Required: stay in SCAN and `all_done` stays 0. When it rises, FINI follows on the next cycle.
- Reset mid-UNPK: assert `reset` with 3 moves pending. Required: `move_valid` 0 and state IDLE on the next cycle; `start` then restarts cleanly.
